pulse_sweep_scheduler: RTL and testbench

Sequences the AD9911 signal-generation block through a frequency-stepped pulse train. For each step it programs a new frequency word, waits for both DDS channels to finish updating, fires one coded pulse, then holds the pulse-repetition interval (PRI) before the next step. It sits between the host/control registers and the SIGNAL generator, and drives that block's FREQW/FREQW_UPDATE/GEN inputs.

---
 rtl/pulse_sched_pkg.sv | 18 +
 rtl/pulse_sweep_scheduler_if.sv | 22 ++
 rtl/req_ack_hs.sv | 48 ++++
 rtl/pulse_sweep_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_pulse_sweep_scheduler.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_sched_pkg.sv
// Shared types and defaults for the frequency-stepped pulse sweep scheduler.
// Holds the FSM state encoding and the width and timeout constants.
package pulse_sched_pkg;

  localparam int FREQW_W         = 32;
  localparam int ACK_TIMEOUT_DEF = 1023;
  localparam int PRI_W_DEF       = 24;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_UPD_REQ  = 3'd1,
    ST_UPD_WAIT = 3'd2,
    ST_GEN_REQ  = 3'd3,
    ST_GEN_WAIT = 3'd4,
    ST_PRI_WAIT = 3'd5
  } state_e;

endpackage

// File: rtl/pulse_sweep_scheduler_if.sv
// Scheduler-to-signal-generator bus: frequency word plus the update and pulse
// request/acknowledge pairs. The scheduler is master, the generator is slave.
interface pulse_sweep_scheduler_if;
  import pulse_sched_pkg::*;

  logic [FREQW_W-1:0] FREQW;
  logic               FREQW_UPDATE;
  logic               FREQW_UPDATE_OVER;
  logic               GEN;
  logic               GEN_OVER;

  modport master (
    output FREQW, FREQW_UPDATE, GEN,
    input  FREQW_UPDATE_OVER, GEN_OVER
  );

  modport slave (
    input  FREQW, FREQW_UPDATE, GEN,
    output FREQW_UPDATE_OVER, GEN_OVER
  );

endinterface

// File: rtl/req_ack_hs.sv
// One registered request held until its acknowledge is sampled low; the request
// drops the next cycle. Gives up after ACK_TIMEOUT cycles of request-high without ack low.
module req_ack_hs #(
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic CLOCK_10M,
  input  logic RESET_N,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic acked,
  output logic timeout
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic          req_q, req_d;
  logic [TW-1:0] tmr_q, tmr_d;

  always_comb begin
    req_d   = req_q;
    tmr_d   = tmr_q;
    acked   = req_q && !ack;
    // tmr_q counts completed request-high cycles, so this fires on the last allowed one
    timeout = req_q && ack && (tmr_q == TW'(ACK_TIMEOUT - 1));
    if (start) begin
      req_d = 1'b1;
      tmr_d = '0;
    end else if (acked || timeout) begin
      req_d = 1'b0;
    end else if (req_q) begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      req_q <= 1'b0;
      tmr_q <= '0;
    end else begin
      req_q <= req_d;
      tmr_q <= tmr_d;
    end
  end

  assign req = req_q;

endmodule

// File: rtl/pulse_sweep_scheduler.sv
// Steps the generator through a frequency sweep: update word, fire one pulse, hold PRI.
// The next update rises PRI cycles after GEN rises, or the cycle after GEN_OVER if that is later.
module pulse_sweep_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int PRI_W       = PRI_W_DEF
) (
  input  logic                   CLOCK_10M,
  input  logic                   RESET_N,
  input  logic                   START,
  input  logic                   STOP,
  input  logic                   CONT,
  input  logic [FREQW_W-1:0]     START_FREQW,
  input  logic [FREQW_W-1:0]     STEP_FREQW,
  input  logic [7:0]             NUM_STEPS,
  input  logic [PRI_W-1:0]       PRI,
  pulse_sweep_scheduler_if.master gen_if,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [7:0]             STEP_IDX,
  output logic                   ERR,
  output logic                   PRI_OVERRUN
);

  state_e             state_q, state_d;
  logic [FREQW_W-1:0] freqw_q, freqw_d, start_fw_q, start_fw_d, step_fw_q, step_fw_d;
  logic [7:0]         num_q, num_d, step_idx_q, step_idx_d;
  logic [PRI_W-1:0]   pri_q, pri_d, cnt_q, cnt_d;
  logic               cont_q, cont_d, busy_q, busy_d, done_q, done_d;
  logic               err_q, err_d, ovr_q, ovr_d, stop_q, stop_d;

  logic upd_go, gen_go, upd_req, gen_req;
  logic upd_acked, upd_timeout, gen_acked, gen_timeout;
  logic advance, finish, abort, last, pri_exp, stop_pend;

  req_ack_hs #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_upd_hs (
    .CLOCK_10M (CLOCK_10M),
    .RESET_N   (RESET_N),
    .start     (upd_go),
    .ack       (gen_if.FREQW_UPDATE_OVER),
    .req       (upd_req),
    .acked     (upd_acked),
    .timeout   (upd_timeout)
  );

  req_ack_hs #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_gen_hs (
    .CLOCK_10M (CLOCK_10M),
    .RESET_N   (RESET_N),
    .start     (gen_go),
    .ack       (gen_if.GEN_OVER),
    .req       (gen_req),
    .acked     (gen_acked),
    .timeout   (gen_timeout)
  );

  always_comb begin
    state_d    = state_q;
    freqw_d    = freqw_q;
    start_fw_d = start_fw_q;
    step_fw_d  = step_fw_q;
    num_d      = num_q;
    pri_d      = pri_q;
    cont_d     = cont_q;
    step_idx_d = step_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    ovr_d      = ovr_q;
    stop_d     = stop_q;
    cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    upd_go     = 1'b0;
    gen_go     = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    last       = (step_idx_q == num_q - 8'd1);
    // Counter hits zero at this edge (or already has), so the next update may rise next cycle
    pri_exp    = (cnt_q <= PRI_W'(1));
    stop_pend  = stop_q || STOP;

    if (state_q != ST_IDLE && STOP) stop_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (NUM_STEPS != 8'd0) begin
            start_fw_d = START_FREQW;
            step_fw_d  = STEP_FREQW;
            num_d      = NUM_STEPS;
            pri_d      = PRI;
            cont_d     = CONT;
            freqw_d    = START_FREQW;
            step_idx_d = 8'd0;
            err_d      = 1'b0;
            ovr_d      = 1'b0;
            busy_d     = 1'b1;
            upd_go     = 1'b1;
            state_d    = ST_UPD_REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_UPD_REQ: begin
        if (upd_acked)        state_d = ST_UPD_WAIT;
        else if (upd_timeout) abort   = 1'b1;
      end
      ST_UPD_WAIT: begin
        if (gen_if.FREQW_UPDATE_OVER) begin
          gen_go  = 1'b1;
          cnt_d   = pri_q;
          state_d = ST_GEN_REQ;
        end
      end
      ST_GEN_REQ: begin
        if (gen_acked)        state_d = ST_GEN_WAIT;
        else if (gen_timeout) abort   = 1'b1;
      end
      ST_GEN_WAIT: begin
        if (gen_if.GEN_OVER) begin
          if (pri_exp) advance = 1'b1;
          else         state_d = ST_PRI_WAIT;
        end else if (pri_exp) begin
          ovr_d = 1'b1;
        end
      end
      ST_PRI_WAIT: begin
        if (pri_exp) advance = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (stop_pend || (last && !cont_q)) begin
        finish = 1'b1;
      end else begin
        upd_go  = 1'b1;
        state_d = ST_UPD_REQ;
        if (last) begin
          step_idx_d = 8'd0;
          freqw_d    = start_fw_q;
        end else begin
          step_idx_d = step_idx_q + 8'd1;
          freqw_d    = freqw_q + step_fw_q;
        end
      end
    end

    if (finish || abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      stop_d  = 1'b0;
      done_d  = finish;
      if (abort) err_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      freqw_q    <= '0;
      start_fw_q <= '0;
      step_fw_q  <= '0;
      num_q      <= '0;
      pri_q      <= '0;
      cont_q     <= 1'b0;
      step_idx_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      freqw_q    <= freqw_d;
      start_fw_q <= start_fw_d;
      step_fw_q  <= step_fw_d;
      num_q      <= num_d;
      pri_q      <= pri_d;
      cont_q     <= cont_d;
      step_idx_q <= step_idx_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
      stop_q     <= stop_d;
    end
  end

  assign gen_if.FREQW        = freqw_q;
  assign gen_if.FREQW_UPDATE = upd_req;
  assign gen_if.GEN          = gen_req;
  assign BUSY                = busy_q;
  assign DONE                = done_q;
  assign STEP_IDX            = step_idx_q;
  assign ERR                 = err_q;
  assign PRI_OVERRUN         = ovr_q;

endmodule

// File: tb/tb_pulse_sweep_scheduler.sv
// Scoreboard bench: directed sweeps push expected generator events; a negedge monitor pops and compares.
module tb_pulse_sweep_scheduler;
  import pulse_sched_pkg::*;

  localparam int PRI_W = 24;
  localparam int EV_UPD = 0, EV_GEN = 1, EV_DONE = 2, EV_ABORT = 3;

  logic              CLOCK_10M = 1'b0;
  logic              RESET_N = 1'b0;
  logic              START = 1'b0, STOP = 1'b0, CONT = 1'b0;
  logic [31:0]       START_FREQW = '0, STEP_FREQW = '0;
  logic [7:0]        NUM_STEPS = '0;
  logic [PRI_W-1:0]  PRI = '0;
  logic              BUSY, DONE, ERR, PRI_OVERRUN;
  logic [7:0]        STEP_IDX;

  pulse_sweep_scheduler_if gif ();

  pulse_sweep_scheduler #(.ACK_TIMEOUT(1023), .PRI_W(PRI_W)) dut (
    .CLOCK_10M   (CLOCK_10M),
    .RESET_N     (RESET_N),
    .START       (START),
    .STOP        (STOP),
    .CONT        (CONT),
    .START_FREQW (START_FREQW),
    .STEP_FREQW  (STEP_FREQW),
    .NUM_STEPS   (NUM_STEPS),
    .PRI         (PRI),
    .gen_if      (gif),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .STEP_IDX    (STEP_IDX),
    .ERR         (ERR),
    .PRI_OVERRUN (PRI_OVERRUN)
  );

  always #50 CLOCK_10M = ~CLOCK_10M;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          dt;
  } evt_t;

  evt_t exp_q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, last_cyc = 0, gen_rises = 0;
  logic p_upd = 1'b0, p_gen = 1'b0, p_busy = 1'b0;

  // Generator model state
  int upd_cnt = 0, gen_cnt = 0, gen_len = 20;
  bit hang_upd = 1'b0, hang_gen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, expv);
    end
  endtask

  task automatic push_exp(input int k, input logic [31:0] d, input int dt);
    evt_t e;
    e.kind = k; e.data = d; e.dt = dt;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] done_dat(input logic pb, input logic b, input logic e,
                                           input logic o, input logic [7:0] s);
    return {20'b0, pb, b, e, o, s};
  endfunction

  task automatic observe(input int kind, input logic [31:0] data);
    evt_t e;
    int   dt;
    dt       = cyc - last_cyc;
    last_cyc = cyc;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d data 0x%08h, required no event", kind, data);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("evt_kind@%0d", cyc), kind, e.kind);
      chk($sformatf("evt_data@%0d", cyc), data, e.data);
      if (e.dt >= 0) chk($sformatf("evt_dt@%0d", cyc), dt, e.dt);
    end
  endtask

  // Monitor
  always @(negedge CLOCK_10M) begin
    cyc++;
    if (gif.FREQW_UPDATE && !p_upd) observe(EV_UPD, gif.FREQW);
    if (gif.GEN && !p_gen) begin
      gen_rises++;
      observe(EV_GEN, {24'b0, STEP_IDX});
    end
    if (DONE) observe(EV_DONE, {20'b0, p_busy, BUSY, ERR, PRI_OVERRUN, STEP_IDX});
    else if (p_busy && !BUSY) observe(EV_ABORT, {29'b0, ERR, gif.FREQW_UPDATE, gif.GEN});
    p_upd  = gif.FREQW_UPDATE;
    p_gen  = gif.GEN;
    p_busy = BUSY;
  end

  // Ideal generator: acknowledge drops right after a request, update done after 1 cycle, pulse after gen_len
  always @(negedge CLOCK_10M) begin
    if (upd_cnt > 0) begin
      upd_cnt--;
      if (upd_cnt == 0) gif.FREQW_UPDATE_OVER = 1'b1;
    end else if (gif.FREQW_UPDATE && gif.FREQW_UPDATE_OVER && !hang_upd) begin
      gif.FREQW_UPDATE_OVER = 1'b0;
      upd_cnt = 1;
    end
    if (gen_cnt > 0) begin
      gen_cnt--;
      if (gen_cnt == 0) gif.GEN_OVER = 1'b1;
    end else if (gif.GEN && gif.GEN_OVER && !hang_gen) begin
      gif.GEN_OVER = 1'b0;
      gen_cnt = gen_len;
    end
  end

  task automatic cfg(input logic [31:0] sf, input logic [31:0] st, input logic [7:0] n,
                     input int pri, input logic c);
    START_FREQW = sf;
    STEP_FREQW  = st;
    NUM_STEPS   = n;
    PRI         = PRI_W'(pri);
    CONT        = c;
  endtask

  task automatic pulse_start();
    @(negedge CLOCK_10M);
    START = 1'b1;
    @(negedge CLOCK_10M);
    START = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (BUSY && n < budget) begin
      @(negedge CLOCK_10M);
      n++;
    end
    chk({name, "_idle"}, {31'b0, BUSY}, 32'd0);
    repeat (4) @(negedge CLOCK_10M);
    chk({name, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_gen(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (gen_rises < target && n < budget) begin
      @(negedge CLOCK_10M);
      n++;
    end
    chk({name, "_gen_seen"}, (gen_rises >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    gif.FREQW_UPDATE_OVER = 1'b1;
    gif.GEN_OVER          = 1'b1;
    repeat (3) @(negedge CLOCK_10M);
    chk("rst_freqw", gif.FREQW, 32'd0);
    chk("rst_upd",   {31'b0, gif.FREQW_UPDATE}, 32'd0);
    chk("rst_gen",   {31'b0, gif.GEN}, 32'd0);
    chk("rst_busy",  {31'b0, BUSY}, 32'd0);
    chk("rst_done",  {31'b0, DONE}, 32'd0);
    chk("rst_idx",   {24'b0, STEP_IDX}, 32'd0);
    chk("rst_flags", {30'b0, ERR, PRI_OVERRUN}, 32'd0);
    RESET_N = 1'b1;

    // Basic 3-step sweep; START and config changes mid-sweep must be ignored
    gen_len = 20;
    cfg(32'h1000_0000, 32'h0100_0000, 8'd3, 5000, 1'b0);
    push_exp(EV_UPD,  32'h1000_0000, -1);
    push_exp(EV_GEN,  32'd0, 2);
    push_exp(EV_UPD,  32'h1100_0000, 5000);
    push_exp(EV_GEN,  32'd1, 2);
    push_exp(EV_UPD,  32'h1200_0000, 5000);
    push_exp(EV_GEN,  32'd2, 2);
    push_exp(EV_DONE, done_dat(1'b1, 1'b0, 1'b0, 1'b0, 8'd2), 5000);
    pulse_start();
    chk("t1_busy_n1",  {31'b0, BUSY}, 32'd1);
    chk("t1_upd_n1",   {31'b0, gif.FREQW_UPDATE}, 32'd1);
    chk("t1_freqw_n1", gif.FREQW, 32'h1000_0000);
    repeat (100) @(negedge CLOCK_10M);
    cfg(32'hDEAD_0000, 32'h0000_0001, 8'd1, 7, 1'b1);
    pulse_start();
    wait_idle("t1", 20000);
    chk("t1_idx_end", {24'b0, STEP_IDX}, 32'd2);

    // Continuous mode stopped during the second pulse
    gen_len = 30;
    cfg(32'hA000_0000, 32'h0000_0010, 8'd2, 50, 1'b1);
    push_exp(EV_UPD,  32'hA000_0000, -1);
    push_exp(EV_GEN,  32'd0, 2);
    push_exp(EV_UPD,  32'hA000_0010, 50);
    push_exp(EV_GEN,  32'd1, 2);
    push_exp(EV_DONE, done_dat(1'b1, 1'b0, 1'b0, 1'b0, 8'd1), 50);
    pulse_start();
    wait_gen("t2", gen_rises + 2, 500);
    repeat (5) @(negedge CLOCK_10M);
    STOP = 1'b1;
    @(negedge CLOCK_10M);
    STOP = 1'b0;
    wait_idle("t2", 500);

    // Update acknowledge never falls: 1023-cycle request, ERR, no DONE
    hang_upd = 1'b1;
    cfg(32'h0000_0005, 32'h0000_0001, 8'd1, 10, 1'b0);
    push_exp(EV_UPD,   32'h0000_0005, -1);
    push_exp(EV_ABORT, 32'h0000_0004, 1023);
    pulse_start();
    wait_idle("t3", 2000);
    chk("t3_err", {31'b0, ERR}, 32'd1);
    hang_upd = 1'b0;
    gen_len  = 3;
    cfg(32'h0000_0007, 32'h0000_0001, 8'd1, 10, 1'b0);
    push_exp(EV_UPD,  32'h0000_0007, -1);
    push_exp(EV_GEN,  32'd0, 2);
    push_exp(EV_DONE, done_dat(1'b1, 1'b0, 1'b0, 1'b0, 8'd0), 10);
    pulse_start();
    chk("t3_err_cleared", {31'b0, ERR}, 32'd0);
    wait_idle("t3b", 200);

    // Pulse longer than PRI: overrun, next update the cycle after GEN_OVER rises
    gen_len = 2560;
    cfg(32'h0000_0100, 32'h0000_0100, 8'd2, 10, 1'b0);
    push_exp(EV_UPD,  32'h0000_0100, -1);
    push_exp(EV_GEN,  32'd0, 2);
    push_exp(EV_UPD,  32'h0000_0200, 2561);
    push_exp(EV_GEN,  32'd1, 2);
    push_exp(EV_DONE, done_dat(1'b1, 1'b0, 1'b0, 1'b1, 8'd1), 2561);
    pulse_start();
    wait_idle("t4", 8000);

    // Frequency word wraps modulo 2^32
    gen_len = 3;
    cfg(32'hFFFF_FF00, 32'h0000_0200, 8'd2, 10, 1'b0);
    push_exp(EV_UPD,  32'hFFFF_FF00, -1);
    push_exp(EV_GEN,  32'd0, 2);
    push_exp(EV_UPD,  32'h0000_0100, 10);
    push_exp(EV_GEN,  32'd1, 2);
    push_exp(EV_DONE, done_dat(1'b1, 1'b0, 1'b0, 1'b0, 8'd1), 10);
    pulse_start();
    wait_idle("t5", 200);

    // NUM_STEPS=0: DONE the next cycle, nothing else changes
    cfg(32'h0000_1234, 32'h0000_0001, 8'd0, 10, 1'b0);
    push_exp(EV_DONE, done_dat(1'b0, 1'b0, 1'b0, 1'b0, 8'd1), -1);
    pulse_start();
    chk("t5_nop_done",  {31'b0, DONE}, 32'd1);
    chk("t5_nop_busy",  {31'b0, BUSY}, 32'd0);
    chk("t5_nop_upd",   {31'b0, gif.FREQW_UPDATE}, 32'd0);
    chk("t5_nop_freqw", gif.FREQW, 32'h0000_0100);
    wait_idle("t5b", 10);

    // Asynchronous reset while GEN is held high
    hang_gen = 1'b1;
    cfg(32'hCAFE_0000, 32'h0000_0001, 8'd2, 100, 1'b0);
    push_exp(EV_UPD,   32'hCAFE_0000, -1);
    push_exp(EV_GEN,   32'd0, 2);
    push_exp(EV_ABORT, 32'h0000_0000, -1);
    pulse_start();
    wait_gen("t6", gen_rises + 1, 100);
    #10 RESET_N = 1'b0;
    #1;
    chk("t6_rst_gen",   {31'b0, gif.GEN}, 32'd0);
    chk("t6_rst_busy",  {31'b0, BUSY}, 32'd0);
    chk("t6_rst_freqw", gif.FREQW, 32'd0);
    repeat (2) @(negedge CLOCK_10M);
    RESET_N  = 1'b1;
    hang_gen = 1'b0;
    gen_len  = 3;
    cfg(32'h0000_0042, 32'h0000_0001, 8'd1, 10, 1'b0);
    push_exp(EV_UPD,  32'h0000_0042, -1);
    push_exp(EV_GEN,  32'd0, 2);
    push_exp(EV_DONE, done_dat(1'b1, 1'b0, 1'b0, 1'b0, 8'd0), 10);
    pulse_start();
    chk("t6_restart_busy", {31'b0, BUSY}, 32'd1);
    wait_idle("t6", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
